// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order MIPS pipeline: opcodes, the hazard
// scoreboard entry layout and the register-file forwarding select.
package pipe_pkg;

  localparam logic [5:0] LW      = 6'b100011;
  localparam logic [5:0] SW      = 6'b101011;
  localparam logic [5:0] BEQ     = 6'b000100;
  localparam logic [5:0] ADD_IMM = 6'b001000;
  localparam logic [5:0] Jop     = 6'b000010;
  localparam logic [5:0] JALop   = 6'b000011;
  localparam logic [5:0] ALUop   = 6'b000000;

  // rd is stored at a fixed width; narrower specifiers are zero-extended,
  // so register files of up to 256 entries are supported.
  localparam int SB_RD_W = 8;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
  } sb_entry_t;

  localparam int FWD_RF = 0;

endpackage

// File: rtl/pipe_hazard_scoreboard_sb_match.sv
// Per-operand youngest-match priority encoder with a load-latency ready check.
module sb_match
  import pipe_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t [DEPTH:1] ent,
  input  logic [REG_W-1:0]    spec,
  input  logic                used,
  output logic [SEL_W-1:0]    sel,
  output logic                hazard
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (spec != '0) && ent[k].valid &&
          (ent[k].rd == SB_RD_W'(spec))) begin
        sel    = SEL_W'(k);
        hazard = ent[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register hazard scoreboard: issue interlock, operand forwarding
// selects and a saturating stall-cycle counter.
module pipe_hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int REG_W    = $clog2(NREG),
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = $clog2(DEPTH + 1),
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rs,
  input  logic [REG_W-1:0] issue_rt,
  input  logic             issue_rs_used,
  input  logic             issue_rt_used,
  input  logic             issue_wr_en,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t [DEPTH:1] ent;
  logic                hazard_a;
  logic                hazard_b;
  logic                accept;

  sb_match #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_a (
    .ent    (ent),
    .spec   (issue_rs),
    .used   (issue_rs_used),
    .sel    (fwd_a_sel),
    .hazard (hazard_a)
  );

  sb_match #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_b (
    .ent    (ent),
    .spec   (issue_rt),
    .used   (issue_rt_used),
    .sel    (fwd_b_sel),
    .hazard (hazard_b)
  );

  assign stall  = issue_valid & (hazard_a | hazard_b) & ~flush;
  assign accept = issue_valid & ~stall & ~flush;

  // ID -> EX boundary: stalled or flushed instructions enter as bubbles,
  // while older entries always keep advancing toward retirement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent[k] <= ent[k-1];
      end
      ent[1].valid   <= accept & issue_wr_en & (issue_rd != '0);
      ent[1].rd      <= SB_RD_W'(issue_rd);
      ent[1].is_load <= issue_is_load;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed scoreboard bench: the driver queues hand-computed expectations,
// a separate monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_rs_used;
  logic       issue_rt_used;
  logic       issue_wr_en;
  logic [4:0] issue_rd;
  logic       issue_is_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic [15:0] stall_count;

  pipe_hazard_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_rs_used (issue_rs_used),
    .issue_rt_used (issue_rt_used),
    .issue_wr_en   (issue_wr_en),
    .issue_rd      (issue_rd),
    .issue_is_load (issue_is_load),
    .flush         (flush),
    .stall         (stall),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        stall;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  event check_now;

  task automatic compare_one();
    exp_t e;
    e = q.pop_front();
    checks++;
    if (stall === e.stall && fwd_a_sel === e.a && fwd_b_sel === e.b &&
        stall_count === e.cnt) begin
      passed++;
    end else begin
      $display("FAIL %s: got stall=%0b a=%0d b=%0d cnt=%0d, want stall=%0b a=%0d b=%0d cnt=%0d",
               e.name, stall, fwd_a_sel, fwd_b_sel, stall_count,
               e.stall, e.a, e.b, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock or check_now);
      while (q.size() > 0) compare_one();
    end
  end

  task automatic expect_out(input string name, input logic s, input logic [1:0] a,
                            input logic [1:0] b, input logic [15:0] c);
    exp_t e;
    e.name = name; e.stall = s; e.a = a; e.b = b; e.cnt = c;
    q.push_back(e);
  endtask

  // One ID-stage cycle: drive, queue expectation, then cross the clock edge.
  task automatic step(input string name, input logic v,
                      input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu,
                      input logic we, input logic [4:0] rd, input logic ld,
                      input logic fl,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb,
                      input logic [15:0] ec);
    issue_valid = v; issue_rs = rs; issue_rs_used = rsu;
    issue_rt = rt; issue_rt_used = rtu; issue_wr_en = we;
    issue_rd = rd; issue_is_load = ld; flush = fl;
    expect_out(name, es, ea, eb, ec);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    issue_valid = 1'b1; issue_rs = 5'd3; issue_rt = 5'd5;
    issue_rs_used = 1'b1; issue_rt_used = 1'b1; issue_wr_en = 1'b1;
    issue_rd = 5'd7; issue_is_load = 1'b1; flush = 1'b0;
    #2;
    expect_out("reset_outputs", 1'b0, 2'd0, 2'd0, 16'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    //     name           v  rs  rsu rt  rtu we rd  ld fl  stall a  b  cnt
    step("add_r3",        1, 1,  1,  2,  1,  1, 3,  0, 0,  0,   0, 0, 0);
    step("fwd_ex",        1, 3,  1,  0,  0,  1, 8,  0, 0,  0,   1, 0, 0);
    step("fwd_mem",       1, 3,  1,  0,  0,  0, 0,  0, 0,  0,   2, 0, 0);
    step("fwd_wb",        1, 3,  1,  0,  0,  0, 0,  0, 0,  0,   3, 0, 0);
    step("retired_rf",    1, 3,  1,  0,  0,  0, 0,  0, 0,  0,   0, 0, 0);
    step("lw_r5",         1, 1,  1,  0,  0,  1, 5,  1, 0,  0,   0, 0, 0);
    step("load_use",      1, 6,  1,  5,  1,  1, 9,  0, 0,  1,   0, 1, 0);
    step("load_use_go",   1, 6,  1,  5,  1,  1, 9,  0, 0,  0,   0, 2, 1);
    step("unused_and_r0", 1, 9,  0,  0,  1,  1, 0,  0, 0,  0,   0, 0, 1);
    step("r0_not_track",  1, 9,  1,  9,  0,  0, 0,  0, 0,  0,   2, 0, 1);
    step("add_r4_a",      1, 0,  0,  0,  0,  1, 4,  0, 0,  0,   0, 0, 1);
    step("add_r4_b",      1, 4,  1,  0,  0,  1, 4,  0, 0,  0,   1, 0, 1);
    step("youngest_wins", 1, 4,  1,  4,  1,  0, 0,  0, 0,  0,   1, 1, 1);
    step("lw_r4",         1, 0,  0,  0,  0,  1, 4,  1, 0,  0,   0, 0, 1);
    step("young_load",    1, 4,  1,  0,  0,  0, 0,  0, 0,  1,   1, 0, 1);
    step("young_load_go", 1, 4,  1,  0,  0,  0, 0,  0, 0,  0,   2, 0, 2);
    step("lw_r6",         1, 0,  0,  0,  0,  1, 6,  1, 0,  0,   0, 0, 2);
    step("flush_wins",    1, 6,  1,  0,  0,  1, 11, 0, 1,  0,   1, 0, 2);
    step("flush_bubble",  1, 11, 1,  6,  1,  0, 0,  0, 0,  0,   0, 2, 2);
    step("lw_r7",         1, 0,  0,  0,  0,  1, 7,  1, 0,  0,   0, 0, 2);

    issue_valid = 1'b1; issue_rs = 5'd7; issue_rs_used = 1'b1;
    issue_rt = 5'd0; issue_rt_used = 1'b0; issue_wr_en = 1'b0;
    issue_rd = 5'd0; issue_is_load = 1'b0; flush = 1'b0;
    expect_out("stall_before_rst", 1'b1, 2'd1, 2'd0, 16'd2);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 2'd0, 2'd0, 16'd0);
    -> check_now;
    #1;

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
# pipe_hazard_scoreboard

Parametrised hazard scoreboard for the in-order MIPS pipeline. It replaces the fixed EX/MEM/WB interlock and forwarding logic with a shift-register scoreboard of in-flight destination registers. Depth, register count and load-use latency are set by parameters. Each cycle it decides whether the instruction in ID may issue to EX, and selects the forwarding source for each operand. It also counts stall cycles for performance reporting.

## Interface
- NREG, 32: architectural register count; register 0 is hardwired zero.
- REG_W, $clog2(NREG): register specifier width.
- DEPTH, 3: in-flight stages tracked after issue (1 = EX, 2 = MEM, 3 = WB); minimum 1.
- LOAD_LAT, 2: first stage index whose output carries load data; range 1..DEPTH.
- SEL_W, $clog2(DEPTH+1): forwarding select width.
- CNT_W, 16: stall counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_valid  in  1  ID holds a real instruction requesting issue.
- issue_rs, issue_rt  in  REG_W  source specifiers.
- issue_rs_used, issue_rt_used  in  1  the operand is actually read.
- issue_wr_en  in  1  the instruction writes a register.
- issue_rd  in  REG_W  destination (rd or rt, already muxed by the decoder).
- issue_is_load  in  1  the instruction is LW.
- flush  in  1  taken branch or jump; kills the ID instruction.
- stall  out  1  hold IF/ID and inject a bubble into EX.
- fwd_a_sel, fwd_b_sel  out  SEL_W  0 = register file, k = output of stage k.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- State: DEPTH entries e[1..DEPTH], each holding {valid, rd, is_load}.
- An entry at stage k is *ready* if !is_load or k >= LOAD_LAT.
- Match per operand: the operand's *_used bit is 1, its specifier is non-zero, and some e[k].valid has e[k].rd equal to the specifier.
- The youngest match (lowest k) wins. Older matches are ignored.
- Operand sel = k of the youngest match, or 0 if there is no match.
- Hazard: the youngest match for either operand is not ready.
- stall = issue_valid & hazard & ~flush.
- accept = issue_valid & ~stall & ~flush.
- Each clock: e[k+1] <= e[k] for k = 1..DEPTH-1; e[DEPTH] retires and is dropped.
- e[1] <= {accept & issue_wr_en & (issue_rd != 0), issue_rd, issue_is_load}.
- A stall or flush therefore inserts a bubble (valid = 0) at e[1], while older entries keep advancing.
- Flush kills only the ID instruction. Entries already in e[1..DEPTH] are architecturally older and are kept.
- stall_count increments by 1 on each cycle with stall = 1 and saturates at 2^CNT_W - 1.
- The register file writes before it reads, so a retired entry never causes a hazard.
- fwd selects are valid even when stall = 1. Consumers ignore them on stalled cycles.

## Timing
- stall, fwd_a_sel and fwd_b_sel are combinational from the entries and the issue_* and flush inputs; there is no added latency.
- The scoreboard updates on the rising clock edge. Reset is asynchronous.
- Reset values: all entries invalid, stall_count = 0.
- Consequently, after reset: stall = 0, fwd_a_sel = 0, fwd_b_sel = 0 for any issue_* input.
- Load-use with the defaults: a consumer directly behind LW stalls 1 cycle. It then issues with sel = 2 (MEM output).
- With LOAD_LAT = 3, the same consumer stalls 2 cycles and then issues with sel = 3.
- Flush and hazard in the same cycle: flush wins, stall = 0, bubble inserted, stall_count unchanged.
- Reset asserted mid-stall: entries clear immediately (asynchronously). stall drops to 0 in the same cycle.
- A persistent issue_valid with a stall eventually clears, since the blocking entry advances every cycle. The maximum stall is LOAD_LAT - 1 cycles.

## Structure
- Package pipe_pkg holds:
  - opcode constants: LW, SW, BEQ, ADD_IMM, Jop, JALop, ALUop;
  - the scoreboard entry struct {valid, rd, is_load};
  - the FWD_RF = 0 constant.
- One natural sub-module, sb_match, handles per-operand matching: youngest-match priority encoder plus ready check. It is instantiated twice (operands A and B). The entry shift register and the counter stay in the top.

## Test plan
- Reset with all issue_* inputs asserted: stall = 0, fwd_a_sel = 0, fwd_b_sel = 0, stall_count = 0.
- ADD r3 issued, then next cycle ADD with rs = r3: fwd_a_sel = 1, stall = 0; one cycle later a reader of r3 sees sel = 2, then sel = 3, then 0.
- LW r5, then next cycle an instruction with rt = r5: stall = 1 for 1 cycle with stall_count = 1, then issue with fwd_b_sel = 2.
- Writes to r0, or an operand with *_used = 0 matching an in-flight rd: sel = 0, no stall.
- r4 written at both e[1] and e[2], consumer reads r4: sel = 1 (youngest wins). With LW r4 at e[1]: stall = 1.
- Load-use hazard with flush = 1 in the same cycle: stall = 0, e[1] bubble, stall_count unchanged. Assert reset mid-stall: stall falls to 0 without a clock edge.
